// File: rtl/spi_host_pkg.sv
// Shared types and constants for the SPI matrix-multiplier host.
//   host_state_e    : sequencing states of the host FSM
//   TX_BYTES        : operand bytes sent per job (A[0..3], B[0..3])
//   RX_WORDS        : result words read back per job
//   RX_BITS         : bits per result word
//   result_slot_lsb : LSB position of a result word inside the 64-bit result
package spi_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_BYTE,
    TX_GAP,
    WAIT_DONE,
    WAIT_READY,
    RX_WORD,
    RX_GAP,
    FINISH
  } host_state_e;

  localparam int TX_BYTES = 8;
  localparam int RX_WORDS = 4;
  localparam int RX_BITS  = 16;

  // Word 0 (C00) is the most significant slot; 16-bit slots give a shift of 4.
  function automatic logic [5:0] result_slot_lsb(input logic [1:0] word_idx);
    logic [1:0] slot;
    slot = 2'(RX_WORDS - 1) - word_idx;
    return {slot, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI bit engine: generates sclk (idle low) and shifts 8 or 16 bits per
// transfer, MSB first.
//   clk, reset : system clock, synchronous active-high reset
//   go         : load tx_data and start a transfer (ignored mid-transfer by caller)
//   len16      : 1 = 16-bit transfer, 0 = 8-bit transfer (tx_data left-aligned)
//   tx_data    : data to send, MSB in bit 15
//   miso       : serial input, captured as sclk rises
//   sclk, mosi : SPI clock and serial output
//   xfer_done  : one-cycle pulse in the last cycle of the final high phase
//   rx_data    : bits received, shifted in from the LSB
module spi_shift_engine
  import spi_host_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               len16,
  input  logic [RX_BITS-1:0] tx_data,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi,
  output logic               xfer_done,
  output logic [RX_BITS-1:0] rx_data
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic               active;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         bit_cnt;
  logic [RX_BITS-1:0] tx_sreg;
  logic               phase_end;

  assign phase_end = active && (div_cnt == '0);
  assign xfer_done = phase_end && sclk && (bit_cnt == 4'd0);
  // mosi drops to 0 in the same cycle the engine goes inactive.
  assign mosi      = active && tx_sreg[RX_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sreg <= '0;
      rx_data <= '0;
      sclk    <= 1'b0;
    end else if (go) begin
      active  <= 1'b1;
      div_cnt <= DIV_LOAD;
      bit_cnt <= len16 ? 4'd15 : 4'd7;
      tx_sreg <= tx_data;
      rx_data <= '0;
      sclk    <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= DIV_LOAD;
      if (!sclk) begin
        sclk    <= 1'b1;
        rx_data <= {rx_data[RX_BITS-2:0], miso};
      end else begin
        sclk    <= 1'b0;
        tx_sreg <= tx_sreg << 1;
        bit_cnt <= bit_cnt - 4'd1;
        if (bit_cnt == 4'd0) active <= 1'b0;
      end
    end else if (active) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_matmult_host.sv
// SPI host for the 2x2 matrix-multiplier slave: sends A[0..3], B[0..3],
// waits for calc_done, then reads four 16-bit result words.
//   hz100        : system clock
//   reset        : synchronous active-high reset
//   start        : one-cycle job request, accepted only when busy=0
//   mat_a, mat_b : operands, element 0 in bits [31:24]
//   calc_done    : slave calculation complete
//   slave_ready  : slave ready to transmit a word
//   miso         : slave serial data
//   sclk, cs_n, mosi : SPI bus
//   result       : C00=[63:48], C01=[47:32], C10=[31:16], C11=[15:0]
//   busy, done, err  : job status
// Optional macro TIMEOUT_EN bounds WAIT_DONE / WAIT_READY to TIMEOUT cycles
// and reports expiry on err; without it err is tied 0.
//
// state      | meaning
// IDLE       | waiting for start
// TX_BYTE    | shifting one operand byte, cs_n low
// TX_GAP     | cs_n high between operand bytes
// WAIT_DONE  | waiting for calc_done
// WAIT_READY | waiting for slave_ready before a result word
// RX_WORD    | shifting in one 16-bit result word, cs_n low
// RX_GAP     | cs_n high settle before the next WAIT_READY
// FINISH     | raise done, drop busy
module spi_matmult_host
  import spi_host_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
`ifdef TIMEOUT_EN
  , parameter int TIMEOUT  = 10000
`endif
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mat_a,
  input  logic [31:0] mat_b,
  input  logic        calc_done,
  input  logic        slave_ready,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  output logic [63:0] result,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  host_state_e        state, state_next;
  logic [2:0]         byte_idx;
  logic [1:0]         word_idx;
  logic [63:0]        tx_buf;
  logic [GAP_W-1:0]   gap_cnt;
  logic               gap_done;
  logic               eng_go, eng_len16, eng_done;
  logic [RX_BITS-1:0] eng_data, rx_word;
  logic               timed_out, timeout_hit;

  assign gap_done = (gap_cnt == '0);

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk       (hz100),
    .reset     (reset),
    .go        (eng_go),
    .len16     (eng_len16),
    .tx_data   (eng_data),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .xfer_done (eng_done),
    .rx_data   (rx_word)
  );

  always_comb begin
    state_next  = state;
    eng_go      = 1'b0;
    eng_len16   = 1'b0;
    eng_data    = '0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = TX_BYTE;
        eng_go     = 1'b1;
        eng_data   = {mat_a[31:24], 8'h00};
      end
      TX_BYTE: if (eng_done) state_next = TX_GAP;
      TX_GAP: if (gap_done) begin
        if (byte_idx == 3'(TX_BYTES - 1)) begin
          state_next = WAIT_DONE;
        end else begin
          state_next = TX_BYTE;
          eng_go     = 1'b1;
          eng_data   = {tx_buf[63:56], 8'h00};
        end
      end
      WAIT_DONE: begin
        if (calc_done) begin
          state_next = RX_GAP;
        end else if (timed_out) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_READY: begin
        if (slave_ready) begin
          state_next = RX_WORD;
          eng_go     = 1'b1;
          eng_len16  = 1'b1;
        end else if (timed_out) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      RX_WORD: if (eng_done) state_next = (word_idx == 2'(RX_WORDS - 1)) ? FINISH : RX_GAP;
      RX_GAP:  if (gap_done) state_next = WAIT_READY;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      byte_idx <= '0;
      word_idx <= '0;
      tx_buf   <= '0;
      gap_cnt  <= GAP_LOAD;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_next;
      // Registered from the next state so cs_n is glitch-free and aligned with sclk/mosi.
      cs_n    <= !((state_next == TX_BYTE) || (state_next == RX_WORD));
      gap_cnt <= ((state == TX_GAP) || (state == RX_GAP)) ? gap_cnt - 1'b1 : GAP_LOAD;
      case (state)
        IDLE: if (start) begin
          tx_buf   <= {mat_a, mat_b};
          byte_idx <= '0;
          word_idx <= '0;
          result   <= '0;
          busy     <= 1'b1;
          done     <= 1'b0;
        end
        // Byte 0 goes straight from mat_a; shifting afterwards keeps the next byte on top.
        TX_BYTE: if (eng_done) tx_buf <= tx_buf << 8;
        TX_GAP:  if (gap_done && (byte_idx != 3'(TX_BYTES - 1))) byte_idx <= byte_idx + 3'd1;
        RX_WORD: if (eng_done) begin
          result[result_slot_lsb(word_idx) +: RX_BITS] <= rx_word;
          word_idx <= word_idx + 2'd1;
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
      if (timeout_hit) busy <= 1'b0;
    end
  end

`ifdef TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign err       = err_q;

  // RX_GAP always separates WAIT_DONE from WAIT_READY, so each wait starts from 0.
  always_ff @(posedge hz100) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= ((state == WAIT_DONE) || (state == WAIT_READY)) ? wait_cnt + 1'b1 : '0;
      if ((state == IDLE) && start) err_q <= 1'b0;
      else if (timeout_hit)         err_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_matmult_host.sv
module tb_spi_matmult_host;

  logic        hz100 = 1'b0;
  logic        reset, start, calc_done, slave_ready, miso;
  logic [31:0] mat_a, mat_b;
  logic        sclk, cs_n, mosi, busy, done, err;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  always #5 hz100 = ~hz100;

  spi_matmult_host #(
    .CLK_DIV(2),
    .GAP_CYCLES(4)
`ifdef TIMEOUT_EN
    , .TIMEOUT(50)
`endif
  ) dut (
    .hz100(hz100), .reset(reset), .start(start), .mat_a(mat_a), .mat_b(mat_b),
    .calc_done(calc_done), .slave_ready(slave_ready), .miso(miso),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .result(result),
    .busy(busy), .done(done), .err(err)
  );

  // Slave model: captures operand bytes on sclk rising, returns slave_words
  // MSB first, and measures cs_n windows and gaps.
  logic        model_clr = 1'b1;
  logic [7:0]  cap_byte [8];
  logic [7:0]  shift_in;
  logic [15:0] out_sreg;
  logic [15:0] slave_words [4];
  logic        prev_sclk, prev_cs;
  int tx_cnt, rx_cnt, bit_cnt, win_len, win_min, win_max, gap_len, gap_min, bad_bits, rx_mosi_seen;

  assign miso = out_sreg[15];

  always @(posedge hz100) begin
    if (model_clr) begin
      prev_sclk <= 1'b0; prev_cs <= 1'b1; tx_cnt <= 0; rx_cnt <= 0; bit_cnt <= 0;
      win_len <= 0; win_min <= 1000000; win_max <= 0; gap_len <= 0; gap_min <= 1000000;
      bad_bits <= 0; rx_mosi_seen <= 0; shift_in <= 8'h00; out_sreg <= 16'h0000;
      for (int i = 0; i < 8; i++) cap_byte[i] <= 8'h00;
    end else begin
      prev_sclk <= sclk;
      prev_cs   <= cs_n;
      if (!cs_n) begin
        win_len <= prev_cs ? 1 : win_len + 1;
        if (prev_cs && tx_cnt > 0 && tx_cnt < 8 && gap_len < gap_min) gap_min <= gap_len;
        if (sclk && !prev_sclk) begin
          bit_cnt <= bit_cnt + 1;
          if (tx_cnt < 8) shift_in <= {shift_in[6:0], mosi};
          else            out_sreg <= {out_sreg[14:0], 1'b0};
        end
        if (tx_cnt >= 8 && mosi) rx_mosi_seen <= 1;
      end else begin
        gap_len <= prev_cs ? gap_len + 1 : 1;
        if (!prev_cs) begin
          bit_cnt <= 0;
          if (tx_cnt < 8) begin
            cap_byte[tx_cnt] <= shift_in;
            tx_cnt <= tx_cnt + 1;
            if (win_len < win_min) win_min <= win_len;
            if (win_len > win_max) win_max <= win_len;
            if (bit_cnt != 8) bad_bits <= bad_bits + 1;
            if (tx_cnt == 7) out_sreg <= slave_words[0];
          end else begin
            if (bit_cnt != 16) bad_bits <= bad_bits + 1;
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt < 3) out_sreg <= slave_words[rx_cnt + 1];
          end
        end
      end
    end
  end

  task automatic clr_model();
    @(negedge hz100); model_clr = 1'b1;
    @(negedge hz100); model_clr = 1'b0;
  endtask

  // Runs one job; calc_done either high throughout or raised 20 cycles after
  // the last operand byte. poke_at >= 0 pulses start (with junk operands)
  // once that many bytes have been captured.
  task automatic run_xfer(input logic [31:0] a, input logic [31:0] b, input bit cd_early,
                          input int poke_at, output int cyc, output bit hung);
    int since;
    since = 0;
    clr_model();
    calc_done = cd_early; slave_ready = 1'b1;
    mat_a = a; mat_b = b; start = 1'b1;
    @(negedge hz100);
    start = 1'b0; cyc = 1;
    mat_a = 32'hFFFF_FFFF; mat_b = 32'hFFFF_FFFF;
    while (!done && cyc < 5000) begin
      if (poke_at >= 0 && tx_cnt == poke_at) begin start = 1'b1; poke_at = -1; end
      else start = 1'b0;
      if (tx_cnt == 8) since++;
      if (since > 20) calc_done = 1'b1;
      @(negedge hz100); cyc++;
    end
    start = 1'b0; calc_done = 1'b0;
    hung = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; calc_done = 1'b0; slave_ready = 1'b0;
    mat_a = '0; mat_b = '0;
    repeat (3) @(negedge hz100);
    reset = 1'b0; model_clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge hz100);
      checks++;
      if ({sclk, cs_n, mosi, busy, done, err} !== 6'b010000) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got sclk,cs_n,mosi,busy,done,err=%b expected 010000",
                 i, {sclk, cs_n, mosi, busy, done, err});
      end
    end
    checks++;
    if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
  endtask

  task automatic test_basic();
    int cyc; bit hung;
    logic [63:0] exp_bytes;
    exp_bytes = 64'h0102_0304_0506_0708;
    slave_words[0] = 16'h0013; slave_words[1] = 16'h0016;
    slave_words[2] = 16'h002B; slave_words[3] = 16'h0032;
    run_xfer(32'h0102_0304, 32'h0506_0708, 1'b0, -1, cyc, hung);
    checks++; if (hung) begin errors++; $display("FAIL basic_timeout: done never rose in %0d cycles", cyc); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_byte[i] !== exp_bytes[63 - 8*i -: 8]) begin
        errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, cap_byte[i], exp_bytes[63 - 8*i -: 8]);
      end
    end
    checks++; if (win_min != 32 || win_max != 32) begin errors++; $display("FAIL basic_window: got min %0d max %0d expected 32", win_min, win_max); end
    checks++; if (gap_min != 4) begin errors++; $display("FAIL basic_gap: got %0d expected 4", gap_min); end
    checks++; if (bad_bits != 0) begin errors++; $display("FAIL basic_bitcount: got %0d bad windows expected 0", bad_bits); end
    checks++; if (rx_cnt != 4) begin errors++; $display("FAIL basic_rxwords: got %0d expected 4", rx_cnt); end
    checks++; if (rx_mosi_seen != 0) begin errors++; $display("FAIL basic_rx_mosi: got mosi high during read expected 0"); end
    checks++; if (result !== 64'h0013_0016_002B_0032) begin errors++; $display("FAIL basic_result: got %h expected 0013_0016_002b_0032", result); end
    checks++; if ({done, busy, err, cs_n} !== 4'b1001) begin errors++; $display("FAIL basic_status: got done,busy,err,cs_n=%b expected 1001", {done, busy, err, cs_n}); end
  endtask

  task automatic test_matmul();
    int cyc; bit hung;
    logic [63:0] exp_bytes;
    exp_bytes = 64'h81F1_9EAB_C3E7_B395;
    slave_words[0] = 16'h0AC6; slave_words[1] = 16'h00AC;
    slave_words[2] = 16'hEFEB; slave_words[3] = 16'hF219;
    run_xfer(32'h81F1_9EAB, 32'hC3E7_B395, 1'b1, -1, cyc, hung);
    checks++; if (hung) begin errors++; $display("FAIL matmul_timeout: done never rose in %0d cycles", cyc); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_byte[i] !== exp_bytes[63 - 8*i -: 8]) begin
        errors++; $display("FAIL matmul_byte%0d: got %h expected %h", i, cap_byte[i], exp_bytes[63 - 8*i -: 8]);
      end
    end
    checks++; if (result !== 64'h0AC6_00AC_EFEB_F219) begin errors++; $display("FAIL matmul_result: got %h expected 0ac6_00ac_efeb_f219", result); end
    // 8*(32+4) + 1 + 4*(4+1+64) + 1 state cycles, observed one edge later
    checks++; if (cyc != 567) begin errors++; $display("FAIL matmul_latency: got %0d cycles expected 567", cyc); end
  endtask

  task automatic test_busy_start();
    int cyc; bit hung;
    logic [63:0] exp_bytes;
    exp_bytes = 64'h0102_0304_0506_0708;
    slave_words[0] = 16'h0013; slave_words[1] = 16'h0016;
    slave_words[2] = 16'h002B; slave_words[3] = 16'h0032;
    run_xfer(32'h0102_0304, 32'h0506_0708, 1'b0, 3, cyc, hung);
    checks++; if (hung) begin errors++; $display("FAIL busy_timeout: done never rose in %0d cycles", cyc); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_byte[i] !== exp_bytes[63 - 8*i -: 8]) begin
        errors++; $display("FAIL busy_byte%0d: got %h expected %h", i, cap_byte[i], exp_bytes[63 - 8*i -: 8]);
      end
    end
    checks++; if (result !== 64'h0013_0016_002B_0032) begin errors++; $display("FAIL busy_result: got %h expected 0013_0016_002b_0032", result); end
    repeat (10) @(negedge hz100);
    checks++; if ({busy, cs_n, done} !== 3'b011) begin errors++; $display("FAIL busy_idle_after: got busy,cs_n,done=%b expected 011", {busy, cs_n, done}); end
  endtask

  task automatic test_back_to_back();
    checks++; if (result !== 64'h0013_0016_002B_0032) begin errors++; $display("FAIL b2b_result_held: got %h expected 0013_0016_002b_0032", result); end
    @(negedge hz100);
    mat_a = 32'h8011_2233; mat_b = 32'h4455_6677; start = 1'b1;
    @(posedge hz100); #1;
    start = 1'b0;
    checks++;
    if ({done, busy, cs_n, mosi, sclk} !== 5'b01010) begin
      errors++; $display("FAIL b2b_restart: got done,busy,cs_n,mosi,sclk=%b expected 01010", {done, busy, cs_n, mosi, sclk});
    end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL b2b_result_clear: got %h expected 0", result); end
  endtask

  // Continues the transfer launched by test_back_to_back.
  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (cs_n == 1'b0 && guard < 200) begin @(negedge hz100); guard++; end
    while (cs_n == 1'b1 && guard < 400) begin @(negedge hz100); guard++; end
    repeat (5) @(negedge hz100);
    checks++; if (cs_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midreset_precond: got cs_n=%b busy=%b expected 0 1 (guard %0d)", cs_n, busy, guard); end
    reset = 1'b1; start = 1'b1;
    @(posedge hz100); #1;
    checks++;
    if ({sclk, cs_n, mosi, busy, done, err} !== 6'b010000) begin
      errors++; $display("FAIL midreset_outputs: got sclk,cs_n,mosi,busy,done,err=%b expected 010000", {sclk, cs_n, mosi, busy, done, err});
    end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL midreset_result: got %h expected 0", result); end
    @(negedge hz100);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge hz100);
      checks++;
      if ({cs_n, busy, sclk} !== 3'b100) begin
        errors++; $display("FAIL midreset_idle cycle %0d: got cs_n,busy,sclk=%b expected 100", i, {cs_n, busy, sclk});
      end
    end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    int guard, cyc;
    clr_model();
    calc_done = 1'b0; slave_ready = 1'b1;
    mat_a = 32'h0102_0304; mat_b = 32'h0506_0708; start = 1'b1;
    @(negedge hz100); start = 1'b0;
    guard = 0;
    while (tx_cnt != 8 && guard < 2000) begin @(negedge hz100); guard++; end
    cyc = 0;
    while (!err && cyc < 200) begin @(negedge hz100); cyc++; end
    checks++; if (cyc != 53) begin errors++; $display("FAIL timeout_latency: got %0d expected 53", cyc); end
    checks++; if ({err, busy, done, cs_n} !== 4'b1001) begin errors++; $display("FAIL timeout_status: got err,busy,done,cs_n=%b expected 1001", {err, busy, done, cs_n}); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL timeout_result: got %h expected 0", result); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_matmul();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
`ifdef TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_matmult_host.md
Name: spi_matmult_host

Overview:
- SPI initiator (master) for the 2x2 matrix-multiplier slave.
- Sends 8 operand bytes: A[0..3] then B[0..3].
- Waits for the slave's calc_done, then reads back four 16-bit result words.
- Runs on the system clock. Replaces bench-driven SPI so the multiplier can be exercised on-chip from another block or the board harness.

Parameters:
- CLK_DIV, 2, hz100 cycles per SCLK half-period (>=1).
- GAP_CYCLES, 4, cs_n-high cycles between transfers (>=1).
- TIMEOUT, 10000, max hz100 cycles in any wait state (only with TIMEOUT_EN).

Ports:
- hz100  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- mat_a  in  32  A[0]=[31:24], A[1]=[23:16], A[2]=[15:8], A[3]=[7:0]; sampled on accepted start.
- mat_b  in  32  same packing as mat_a for B.
- calc_done  in  1  slave calculation-complete flag (right[0]).
- slave_ready  in  1  slave ready-to-transmit flag (right[2]).
- miso  in  1  slave serial data out (right[3]).
- sclk  out  1  SPI clock, idle low (drives pb[0]).
- cs_n  out  1  chip select, active low (drives pb[1]).
- mosi  out  1  serial data to slave, MSB first (drives pb[2]).
- result  out  64  C00=[63:48], C01=[47:32], C10=[31:16], C11=[15:0].
- busy  out  1  high from accepted start until done/err.
- done  out  1  high once all four words are captured; held until next accepted start or reset.
- err  out  1  timeout flag; held until next accepted start or reset.

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, result=0, busy=0, done=0, err=0. Shift registers and counters cleared. State=IDLE.
- Reset mid-transfer: next edge forces the full reset state; cs_n=1 immediately, no partial-byte completion.
- States: IDLE, TX_BYTE, TX_GAP, WAIT_DONE, WAIT_READY, RX_WORD, RX_GAP, FINISH.
- IDLE:
  - start=1 latches mat_a/mat_b into an 8-byte TX buffer.
  - Clears done/err and byte_idx, sets busy=1, goes to TX_BYTE.
  - start while busy is ignored.
- TX_BYTE:
  - cs_n=0 and mosi=bit7 in the first cycle.
  - sclk sequence: low CLK_DIV cycles, high CLK_DIV cycles, repeated 8 times.
  - mosi advances to the next bit on each high->low sclk transition.
  - After the 8th high phase: sclk=0, cs_n=1, mosi=0 in the same cycle, go to TX_GAP.
  - Byte duration 16*CLK_DIV cycles.
- TX_GAP:
  - Holds cs_n=1 for GAP_CYCLES.
  - byte_idx<7: increment, go to TX_BYTE. byte_idx=7: go to WAIT_DONE.
- WAIT_DONE: stays until calc_done=1, then goes to RX_GAP (GAP_CYCLES settle) and then WAIT_READY.
- WAIT_READY:
  - Stays until slave_ready=1, then goes to RX_WORD.
  - slave_ready is sampled only in this state.
- RX_WORD:
  - Same SCLK timing as TX_BYTE but 16 periods; mosi held 0.
  - miso is registered in the cycle sclk goes low->high and shifted left into a 16-bit register.
  - After the 16th high phase, the word is written to the result slot for word_idx (0=C00 first), cs_n=1.
  - word_idx<3: go to RX_GAP then WAIT_READY. word_idx=3: go to FINISH.
- FINISH: done=1, busy=0, go to IDLE. result is stable until the next accepted start.
- Arithmetic/width: all index counters wrap-safe; byte_idx 3 bits, word_idx 2 bits, bit counter 4 bits, divider counter $clog2(CLK_DIV)+1 bits.
- Simultaneous events:
  - calc_done already high on entry to WAIT_DONE: leave on the next cycle.
  - start and reset in the same cycle: reset wins.

Optional Feature:
- TIMEOUT_EN.
- Defined: WAIT_DONE and WAIT_READY each count cycles. At TIMEOUT cycles the block sets err=1, busy=0, done=0, cs_n=1 and returns to IDLE. result keeps words captured so far; unfilled slots stay 0.
- Undefined: no counter; waits are unbounded and err is tied 0.

Decomposition:
- Package spi_host_pkg holds:
  - the state enum typedef;
  - constants TX_BYTES=8, RX_WORDS=4, RX_BITS=16;
  - the result slot index mapping.
- One sub-module, spi_shift_engine:
  - generates sclk from CLK_DIV;
  - shifts N bits (8 or 16 selected per transfer) out on mosi and in from miso;
  - pulses xfer_done.
- The top FSM sequences bytes, words, gaps and waits.

Test Plan:
- Reset then idle, no start -> sclk=0, cs_n=1, mosi=0, busy=0, done=0 for 100 cycles.
- Slave model, A=01,02,03,04, B=05,06,07,08, CLK_DIV=2 -> the model captures exactly those 8 bytes in order, each cs_n-low window lasts 32 cycles and gaps are >=4 cycles.
- Same run, slave returns 0x0013,0x0016,0x002B,0x0032 -> result=64'h0013_0016_002B_0032, done=1, busy=0.
- A=81,F1,9E,AB, B=C3,E7,B3,95 against the real multiplier -> result words equal the 16-bit truncation of the 2x2 product, C00=16'h0AC6.
- start pulsed while busy, and reset asserted mid-TX_BYTE -> extra start has no effect; after reset, cs_n=1 on the next edge and all outputs are at reset values.
- TIMEOUT_EN, TIMEOUT=50, calc_done held 0 -> err=1 on the 50th WAIT_DONE cycle, busy=0, result=0.
